// File: rtl/var_delay_line.sv
// var_delay_line: programmable-length sample delay line on an inferred
// simple-dual-port RAM used as a circular buffer.
//
// Ports:
//   clk       single clock, all logic on posedge
//   rst       synchronous reset, active-high; also latches len_i
//   len_i     requested delay in samples (clamped to 1..MAX_LEN)
//   len_load  strobe: latch len_i and flush the line
//   in_valid  di accepted this cycle (always ready)
//   di        input sample
//   out_valid data_o holds a valid delayed sample this cycle
//   data_o    sample accepted len_q samples before the latest one
//   fill_o    samples held in the buffer, saturating at len_q
module var_delay_line #(
  parameter int DATA_WIDTH = 25,
  parameter int MAX_LEN    = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic                  len_load,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] di,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ADDR_WIDTH:0]   fill_o
);

  localparam logic [ADDR_WIDTH:0] MAX_L =
    (ADDR_WIDTH+1)'(MAX_LEN);
  localparam logic [ADDR_WIDTH:0] ONE =
    (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE =
    ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [MAX_LEN];

  logic [ADDR_WIDTH:0]   len_c;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   len_m1;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   fill;
  logic                  ptr_last;
  logic                  full;
  logic                  ld_one;
  logic                  we;
  logic                  rd_en;

  // Zero-length is meaningless for a registered RAM
  // path, so it degrades to a one-sample delay.
  always_comb begin
    len_c = len_i;
    if (len_i == '0)
      len_c = ONE;
    else if (len_i > MAX_L)
      len_c = MAX_L;
  end

  assign len_m1   = len_q - ONE;
  assign ptr_last = ({1'b0, wr_ptr} == len_m1);
  assign full     = (fill == len_q);
  assign ld_one   = (len_c == ONE);

  // A load with a sample restarts the sequence at
  // address 0, so the sample is written there.
  assign wr_addr = len_load ? '0 : wr_ptr;
  assign we      = in_valid & ~rst;

  // Output only once a full len_q history exists;
  // this masks whatever stale words the RAM holds.
  assign rd_en   = in_valid & ~len_load & full;

  assign fill_o  = fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= len_c;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (len_load) begin
      len_q <= len_c;
      if (in_valid) begin
        wr_ptr <= ld_one ? '0 : PTR_ONE;
        fill   <= ONE;
      end else begin
        wr_ptr <= '0;
        fill   <= '0;
      end
    end else if (in_valid) begin
      wr_ptr <= ptr_last ? '0 : wr_ptr + PTR_ONE;
      fill   <= full ? fill : fill + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      out_valid <= 1'b0;
    else
      out_valid <= rd_en;
  end

  // Write port: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (we)
      mem[wr_addr] <= di;
  end

  // Registered read port, read-first against the
  // write to the same address in this cycle.
  always_ff @(posedge clk) begin
    if (rst)
      data_o <= '0;
    else if (rd_en)
      data_o <= mem[wr_ptr];
  end

endmodule

// File: tb/tb_var_delay_line.sv
// tb_var_delay_line: directed + random steps checked
// against a queue-based model of the delay line.
module tb_var_delay_line;

  localparam int DW = 25;
  localparam int ML = 1024;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   len_i;
  logic          len_load;
  logic          in_valid;
  logic [DW-1:0] di;
  logic          out_valid;
  logic [DW-1:0] data_o;
  logic [AW:0]   fill_o;

  var_delay_line #(
    .DATA_WIDTH(DW),
    .MAX_LEN(ML),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .len_i(len_i),
    .len_load(len_load),
    .in_valid(in_valid),
    .di(di),
    .out_valid(out_valid),
    .data_o(data_o),
    .fill_o(fill_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the last L accepted samples, oldest first.
  logic [DW-1:0] hist[$];
  int            mlen;
  bit            e_ov;
  logic [DW-1:0] e_do;

  function automatic int clampf(input int x);
    if (x == 0) return 1;
    if (x > ML) return ML;
    return x;
  endfunction

  task automatic step(input bit r, input bit ld,
                      input int len, input bit v,
                      input logic [DW-1:0] d);
    @(negedge clk);
    rst      = r;
    len_load = ld;
    len_i    = (AW+1)'(len);
    in_valid = v;
    di       = d;
    if (r) begin
      hist.delete();
      mlen = clampf(len);
      e_ov = 0;
      e_do = '0;
    end else if (ld) begin
      hist.delete();
      mlen = clampf(len);
      if (v) hist.push_back(d);
      e_ov = 0;
    end else if (v) begin
      e_ov = 0;
      if (hist.size() == mlen) begin
        e_ov = 1;
        e_do = hist.pop_front();
      end
      hist.push_back(d);
    end else begin
      e_ov = 0;
    end
    @(posedge clk);
    #1;
    n_tests++;
    assert (out_valid === e_ov) else begin
      n_fail++;
      $error("FAIL out_valid got %0b exp %0b",
             out_valid, e_ov);
    end
    n_tests++;
    assert (data_o === e_do) else begin
      n_fail++;
      $error("FAIL data_o got %0d exp %0d",
             data_o, e_do);
    end
    n_tests++;
    assert (fill_o === (AW+1)'(hist.size())) else begin
      n_fail++;
      $error("FAIL fill_o got %0d exp %0d",
             fill_o, hist.size());
    end
  endtask

  initial begin
    rst = 1; len_load = 0; len_i = 4;
    in_valid = 0; di = '0;
    mlen = 4; e_ov = 0; e_do = '0;

    // 1: len 4, di 1..10
    step(1, 0, 4, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++)
      step(0, 0, 0, 1, DW'(i));
    n_tests++;
    assert (data_o === DW'(6) && fill_o === 11'd4)
    else begin
      n_fail++;
      $error("FAIL t1_end got %0d/%0d exp 6/4",
             data_o, fill_o);
    end

    // 2: len 1, di 7,8,9
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 7);
    step(0, 0, 0, 1, 8);
    step(0, 0, 0, 1, 9);
    n_tests++;
    assert (out_valid === 1'b1 && data_o === DW'(8))
    else begin
      n_fail++;
      $error("FAIL t2_end got %0b/%0d exp 1/8",
             out_valid, data_o);
    end

    // 3: len 3, ~50% valid, di 1..20 on accepts
    step(0, 1, 3, 0, 0);
    begin
      int k = 1;
      while (k <= 20) begin
        if ($urandom_range(1) == 1) begin
          step(0, 0, 0, 1, DW'(k));
          k++;
        end else begin
          step(0, 0, 0, 0, DW'($urandom));
        end
      end
    end

    // 4: len 4 to 12, reload len 2 with di=13
    step(0, 1, 4, 0, 0);
    for (int i = 1; i <= 12; i++)
      step(0, 0, 0, 1, DW'(i));
    step(0, 1, 2, 1, 13);
    for (int i = 14; i <= 16; i++)
      step(0, 0, 0, 1, DW'(i));

    // 5: clamp low and high, full-depth wrap
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      step(0, 0, 0, 1, DW'(100 + i));
    step(0, 1, ML + 5, 0, 0);
    for (int i = 1; i <= 2 * ML + 2; i++)
      step(0, 0, 0, 1, DW'(i));
    n_tests++;
    assert (data_o === DW'(ML + 2)) else begin
      n_fail++;
      $error("FAIL t5_wrap got %0d exp %0d",
             data_o, ML + 2);
    end

    // 6: reset mid-stream at len 8
    step(0, 1, 8, 0, 0);
    for (int i = 1; i <= 12; i++)
      step(0, 0, 0, 1, DW'(i));
    step(1, 0, 8, 1, 99);
    n_tests++;
    assert (out_valid === 1'b0 && data_o === '0 &&
            fill_o === '0) else begin
      n_fail++;
      $error("FAIL t6_rst got %0b/%0d/%0d exp 0/0/0",
             out_valid, data_o, fill_o);
    end
    for (int i = 0; i < 14; i++)
      step(0, 0, 0, $urandom_range(3) != 0,
           DW'($urandom));

    // Random mix of loads, resets and gaps
    for (int i = 0; i < 400; i++) begin
      int sel = $urandom_range(99);
      int ln  = $urandom_range(12);
      if (sel < 2)
        step(1, 0, ln, $urandom_range(1), DW'($urandom));
      else if (sel < 6)
        step(0, 1, ln, $urandom_range(1), DW'($urandom));
      else
        step(0, 0, 0, $urandom_range(3) != 0,
             DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
